// File: rtl/rtc_digit_scan_ctrl_if.sv
// Digit-scan bus between the RTC digit sequencer and its environment:
// scan request, the three BCD banks, decoder drive and the renderer handshake.
// The master side requests scans and renders digits; the slave side is the
// sequencer.
interface rtc_digit_scan_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic          start;
    logic [1:0]    bank_sel;
    logic [BW-1:0] time_bcd;
    logic [BW-1:0] date_bcd;
    logic [BW-1:0] timer_bcd;
    logic          dec_enable;
    logic [3:0]    dec_bcd;
    logic [IW-1:0] digit_idx;
    logic          digit_valid;
    logic          digit_ready;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, bank_sel, time_bcd, date_bcd, timer_bcd, digit_ready,
        input  dec_enable, dec_bcd, digit_idx, digit_valid, busy, done, err
    );

    modport slave (
        input  start, bank_sel, time_bcd, date_bcd, timer_bcd, digit_ready,
        output dec_enable, dec_bcd, digit_idx, digit_valid, busy, done, err
    );
endinterface

// File: rtl/rtc_digit_scan_ctrl.sv
// RTC digit scan sequencer: time-shares one BCD digit decoder between the
// time, date and countdown-timer banks. A start request snapshots the chosen
// bank, then each digit (MS nibble first) is driven to the decoder, allowed to
// settle for WAIT_CYCLES, and offered to the renderer with valid/ready.
// Optional feature macro: SCAN_BLANK_LEADING_ZERO_EN blanks a zero in digit 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start, decoder disabled
// LOAD    | snapshot selected bank, clear err, index back to digit 0
// SETTLE  | decoder driven, down-counting decoder/ROM settle time
// PRESENT | digit_valid high, everything held until renderer accepts
// DONE    | one-cycle done pulse, then back to IDLE
module rtc_digit_scan_ctrl #(
    parameter int NUM_DIGITS  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    rtc_digit_scan_ctrl_if.slave bus_if
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] snap_q, snap_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          blank_q, blank_d;

    logic [3:0]    nib;
    logic          nib_bad;
    logic          lead_zero;
    logic          scan_active;

    // Digit currently on the decoder is always the top nibble of the snapshot.
    assign nib     = snap_q[BW-1 -: 4];
    assign nib_bad = (nib > 4'd9);

`ifdef SCAN_BLANK_LEADING_ZERO_EN
    assign lead_zero = (idx_q == '0) && (nib == 4'd0);
`else
    assign lead_zero = 1'b0;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            blank_q <= blank_d;
        end
    end

    // Next-state logic: snapshot, settle countdown, handshake and digit advance.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        blank_d = blank_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                case (bus_if.bank_sel)
                    2'd0:    snap_d = bus_if.time_bcd;
                    2'd1:    snap_d = bus_if.date_bcd;
                    2'd2:    snap_d = bus_if.timer_bcd;
                    default: snap_d = '0;
                endcase
                blank_d = (bus_if.bank_sel == 2'd3);
                err_d   = 1'b0;
                idx_d   = '0;
                cnt_d   = CNT_LOAD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (nib_bad) err_d = 1'b1;
                if (cnt_q == '0) state_d = S_PRESENT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_PRESENT: begin
                if (bus_if.digit_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        snap_d  = snap_q << 4;
                        cnt_d   = CNT_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decoder drive and status outputs, all derived from registered state.
    always_comb begin
        scan_active        = (state_q == S_SETTLE) || (state_q == S_PRESENT);
        bus_if.dec_enable  = scan_active && !blank_q && !nib_bad && !lead_zero;
        bus_if.dec_bcd     = (scan_active && !blank_q) ? nib : 4'd0;
        bus_if.digit_idx   = idx_q;
        bus_if.digit_valid = (state_q == S_PRESENT);
        bus_if.busy        = (state_q != S_IDLE);
        bus_if.done        = (state_q == S_DONE);
        bus_if.err         = err_q;
    end
endmodule

// File: tb/tb_rtc_digit_scan_ctrl.sv
// Bench for rtc_digit_scan_ctrl: directed scans of the time/date/timer/blank
// banks with a digit-list model and an every-cycle output comparator.
module tb_rtc_digit_scan_ctrl;
    localparam int ND = 6;

`ifdef SCAN_BLANK_LEADING_ZERO_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_digit_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    rtc_digit_scan_ctrl #(.NUM_DIGITS(ND), .WAIT_CYCLES(2)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_if  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // expected per-digit view of the current scan
    logic [3:0] exp_bcd[ND];
    logic       exp_en[ND];
    logic       exp_err[ND];
    int         hs = 0;

    // what the bench saw at each accepted handshake
    int         vcyc[ND];
    logic       en_at[ND];
    logic [3:0] bcd_at[ND];
    int         nval, done_cyc, ndone, busy_first, busy_last;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Digit list for a bank value: MS nibble first, blank bank presents zeros
    // undecoded, non-BCD digits are undecoded and make err stick from then on.
    task automatic build_model(input logic [1:0] sel, input logic [23:0] val);
        logic seen_bad;
        logic [3:0] d;
        seen_bad = 1'b0;
        for (int k = 0; k < ND; k++) begin
            d = 4'((val >> (4 * (ND - 1 - k))) & 24'hF);
            if (sel == 2'd3) begin
                exp_bcd[k] = 4'd0;
                exp_en[k]  = 1'b0;
            end else begin
                exp_bcd[k] = d;
                if (d > 4'd9) seen_bad = 1'b1;
                exp_en[k]  = (d <= 4'd9) && !(LZ && k == 0 && d == 4'd0);
            end
            exp_err[k] = seen_bad;
        end
    endtask

    // Every-cycle comparator: presented digits against the model, quiet when idle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.start && !bus.busy) hs = 0;
            if (bus.digit_valid) begin
                if (hs >= ND) begin
                    chk("digit_overrun", hs, ND - 1);
                end else begin
                    chk("digit_idx", int'(bus.digit_idx), hs);
                    chk("dec_bcd", int'(bus.dec_bcd), int'(exp_bcd[hs]));
                    chk("dec_enable", int'(bus.dec_enable), int'(exp_en[hs]));
                    chk("err", int'(bus.err), int'(exp_err[hs]));
                end
                if (bus.digit_ready) hs++;
            end else if (!bus.busy) begin
                chk("idle_dec_enable", int'(bus.dec_enable), 0);
                chk("idle_done", int'(bus.done), 0);
            end
            if (bus.done) chk("done_after_all_digits", hs, ND);
        end
    end

    // One full scan starting now (caller sits 1 time unit after an edge).
    task automatic do_scan(input logic [1:0] sel, input logic [23:0] val,
                           input int stall_digit, input int stall_len);
        int stall;
        build_model(sel, val);
        bus.time_bcd    = (sel == 2'd0) ? val : 24'h111111;
        bus.date_bcd    = (sel == 2'd1) ? val : 24'h222222;
        bus.timer_bcd   = (sel == 2'd2) ? val : 24'h333333;
        bus.bank_sel    = sel;
        bus.digit_ready = 1'b1;
        nval = 0; done_cyc = -1; ndone = 0; busy_first = -1; busy_last = -1;
        stall = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (c == 2) chk("err_cleared_in_load", int'(bus.err), 0);
            if (bus.digit_valid && int'(bus.digit_idx) == stall_digit && stall < stall_len) begin
                bus.digit_ready = 1'b0;
                stall++;
            end else begin
                bus.digit_ready = 1'b1;
            end
            if (bus.digit_valid && bus.digit_ready) begin
                if (nval < ND) begin
                    vcyc[nval]   = c;
                    en_at[nval]  = bus.dec_enable;
                    bcd_at[nval] = bus.dec_bcd;
                end
                nval++;
            end
            if (bus.done) begin
                if (done_cyc < 0) done_cyc = c;
                ndone++;
                bus.start = 1'b1;
            end else begin
                bus.start = (c == 0 || c == 5 || c == 12);
            end
            if (c == 8) begin
                bus.time_bcd  = 24'hFFFFFF;
                bus.date_bcd  = 24'hEEEEEE;
                bus.timer_bcd = 24'hDDDDDD;
                bus.bank_sel  = sel ^ 2'd1;
            end
            if (done_cyc >= 0 && c >= done_cyc + 6) break;
            tick();
        end
        bus.start = 1'b0;
        chk("scan_completed", int'(done_cyc >= 0), 1);
        chk("handshake_count", nval, ND);
        chk("done_pulse_count", ndone, 1);
        chk("busy_first_cycle", busy_first, 1);
        chk("busy_last_cycle", busy_last, done_cyc);
    endtask

    initial begin
        int cnt_busy, cnt_done;
        // 1: reset with start held high
        bus.start = 1'b1; bus.bank_sel = 2'd0; bus.digit_ready = 1'b1;
        bus.time_bcd = 24'h123456; bus.date_bcd = '0; bus.timer_bcd = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_valid", int'(bus.digit_valid), 0);
        chk("rst_dec_enable", int'(bus.dec_enable), 0);
        chk("rst_dec_bcd", int'(bus.dec_bcd), 0);
        chk("rst_digit_idx", int'(bus.digit_idx), 0);
        chk("rst_err", int'(bus.err), 0);
        bus.start = 1'b0;
        rst_n = 1'b1;
        cnt_busy = 0;
        repeat (3) begin tick(); cnt_busy += int'(bus.busy); end
        chk("post_rst_no_activity", cnt_busy, 0);

        // 4: date bank with a non-BCD digit
        do_scan(2'd1, 24'h3A1299, -1, 0);
        chk("date_en_digit0", int'(en_at[0]), 1);
        chk("date_en_digit1", int'(en_at[1]), 0);
        chk("date_en_digit2", int'(en_at[2]), 1);
        chk("date_bcd_digit1", int'(bcd_at[1]), 10);
        chk("date_err_sticky", int'(bus.err), 1);

        // 2: time 12:34:56, ready tied high; also clears err from previous scan
        do_scan(2'd0, 24'h123456, -1, 0);
        for (int k = 0; k < ND; k++) begin
            chk("time_valid_cycle", vcyc[k], 4 + 3 * k);
            chk("time_digit_value", int'(bcd_at[k]), k + 1);
        end
        chk("time_done_cycle", done_cyc, 20);
        chk("time_err_clear", int'(bus.err), 0);

        // 3: backpressure on digit 2 for 5 cycles, bank change mid-scan
        do_scan(2'd0, 24'h987654, 2, 5);
        chk("bp_digit1_cycle", vcyc[1], 7);
        chk("bp_digit2_cycle", vcyc[2], 15);
        chk("bp_digit3_cycle", vcyc[3], 18);
        chk("bp_done_cycle", done_cyc, 25);
        chk("bp_digit5_value", int'(bcd_at[5]), 4);

        // 5: blank bank, start pulses while busy
        do_scan(2'd3, 24'h000000, -1, 0);
        for (int k = 0; k < ND; k++) chk("blank_en", int'(en_at[k]), 0);
        chk("blank_done_cycle", done_cyc, 20);

        // 6: leading-zero handling on the timer bank
        do_scan(2'd2, 24'h090507, -1, 0);
        chk("lz_digit0_en", int'(en_at[0]), LZ ? 0 : 1);
        chk("lz_digit1_en", int'(en_at[1]), 1);
        chk("lz_digit1_value", int'(bcd_at[1]), 9);

        // 6: reset mid-scan aborts with no done pulse
        build_model(2'd0, 24'h123456);
        bus.bank_sel = 2'd0; bus.time_bcd = 24'h123456; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_dec_enable", int'(bus.dec_enable), 0);
        chk("abort_valid", int'(bus.digit_valid), 0);
        chk("abort_done", int'(bus.done), 0);
        rst_n = 1'b1;
        cnt_busy = 0; cnt_done = 0;
        repeat (25) begin
            tick();
            cnt_busy += int'(bus.busy);
            cnt_done += int'(bus.done);
        end
        chk("abort_no_restart", cnt_busy, 0);
        chk("abort_no_done", cnt_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
